// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the sequencer state encoding, the opcode values and the default sizes.
package multdiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_ITER  = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } md_state_e;

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring-division step, purely combinational.
// Shifts {rem, quo} left by one and trial-subtracts the divisor; on a borrow the shifted
// remainder is kept, otherwise the difference is kept and a quotient bit is set.
// Ports:
//   rem, quo, divisor : current partial remainder, quotient/dividend shift register, divisor
//   rem_next, quo_next: values after the step
// Operands are magnitudes, so rem < divisor <= 2^(WIDTH-1) and the shifted remainder
// always fits in WIDTH bits; bit WIDTH of the difference is therefore a clean borrow.
module multdiv_div_step
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / signed restoring divide feeding HI/LO.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start, op, a, b  : one-cycle request (op 0 = mult, 1 = div), sampled only when idle
//   busy             : high whenever not idle
//   done, div_zero   : one-cycle completion pulse, divide-by-zero flag alongside it
//   hi, lo           : mult -> product high/low; div -> remainder/quotient
// Optional feature: define MULTDIV_FAST_MULT_EN to compute mult with a single registered
// signed multiply (IDLE -> FIX, two cycles in FIX) instead of the Booth iterations.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MULTDIV_FAST_MULT_EN
  localparam bit FastMult = 1'b1;
`else
  localparam bit FastMult = 1'b0;
`endif

  localparam logic [5:0] LastIter = 6'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [5:0]       cnt_q;
  logic             op_q;
  logic             a_neg_q, b_neg_q;
  logic             dz_q;
  // acc_q: Booth accumulator / division remainder.
  // mq_q : Booth multiplier / division dividend-then-quotient.
  // m_q  : multiplicand / divisor magnitude.
  logic [WIDTH-1:0] acc_q, mq_q, m_q;
  logic             q_m1_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             start_div_zero;
  logic             fix_wait;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] div_rem, div_quo;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign start_div_zero = (op == OP_DIV) && (b == '0);
  // Fast mult enters FIX with cnt_q == 0: first FIX cycle loads the product.
  assign fix_wait = FastMult && (op_q == OP_MULT) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (start_div_zero)                  state_d = StDone;
          else if (FastMult && op == OP_MULT)  state_d = StFix;
          else                                 state_d = StRun;
        end
      end
      StRun:   if (cnt_q == LastIter) state_d = StFix;
      StFix:   if (!fix_wait) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Booth step: add/subtract multiplicand per {q0, q-1}; a WIDTH+1 bit sum absorbs the
  // overflow of subtracting the most negative multiplicand before the arithmetic shift.
  always_comb begin
    booth_sum = {acc_q[WIDTH-1], acc_q};
    case ({mq_q[0], q_m1_q})
      2'b01:   booth_sum = {acc_q[WIDTH-1], acc_q} + {m_q[WIDTH-1], m_q};
      2'b10:   booth_sum = {acc_q[WIDTH-1], acc_q} - {m_q[WIDTH-1], m_q};
      default: booth_sum = {acc_q[WIDTH-1], acc_q};
    endcase
  end

  multdiv_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem     (acc_q),
    .quo     (mq_q),
    .divisor (m_q),
    .rem_next(div_rem),
    .quo_next(div_quo)
  );

  // Sign fix-up: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    fix_hi = acc_q;
    fix_lo = mq_q;
    if (op_q == OP_DIV) begin
      if (a_neg_q ^ b_neg_q) fix_lo = -mq_q;
      if (a_neg_q)           fix_hi = -acc_q;
    end
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      mq_q    <= '0;
      m_q     <= '0;
      q_m1_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= op;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_m1_q  <= 1'b0;
            dz_q    <= start_div_zero;
            a_neg_q <= (op == OP_DIV) && a[WIDTH-1];
            b_neg_q <= (op == OP_DIV) && b[WIDTH-1];
            if (op == OP_DIV) begin
              // Magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
              mq_q <= a[WIDTH-1] ? -a : a;
              m_q  <= b[WIDTH-1] ? -b : b;
            end else begin
              mq_q <= b;
              m_q  <= a;
            end
          end
        end
        StRun: begin
          cnt_q <= cnt_q + 6'd1;
          if (op_q == OP_MULT) begin
            acc_q  <= booth_sum[WIDTH:1];
            mq_q   <= {booth_sum[0], mq_q[WIDTH-1:1]};
            q_m1_q <= mq_q[0];
          end else begin
            acc_q <= div_rem;
            mq_q  <= div_quo;
          end
        end
        StFix: begin
          if (fix_wait) begin
`ifdef MULTDIV_FAST_MULT_EN
            {acc_q, mq_q} <= $signed(m_q) * $signed(mq_q);
            cnt_q         <= 6'd1;
`endif
          end else begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign div_zero = (state_q == StDone) && dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: the driver pushes the expected result (from plain
// 64-bit signed arithmetic) and completion cycle; a monitor pops on every done pulse.
module tb_multdiv_sequencer;

`ifdef MULTDIV_FAST_MULT_EN
  localparam int MultLat = 2;
`else
  localparam int MultLat = 33;
`endif
  localparam int DivLat = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  multdiv_sequencer #(
    .WIDTH(32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers, truncated to 32 bits.
  task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                       output exp_t e);
    longint sx, sy, p, q, r;
    sx = $signed(x);
    sy = $signed(y);
    e.dz = 1'b0;
    if (o == 1'b0) begin
      p = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == 32'd0) begin
      e.hi = model_hi;
      e.lo = model_lo;
      e.dz = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 64'(cyc), 64'(-1));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_zero", 64'(div_zero), 64'(e.dz));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one operation from a negedge; return at the negedge where busy is low.
  // inj_at: busy cycle at which a second start is pulsed; rst_at: busy cycle for reset.
  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input int inj_at, input int rst_at);
    exp_t e;
    int   n, k, lat;
    model(o, x, y, e);
    k = cyc + 1;
    lat = (o == 1'b0) ? MultLat : DivLat;
    if (e.dz) lat = 0;
    e.cyc = k + lat;
    sbq.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = $urandom_range(0, 1);
    n = 0;
    while (busy && n < 100) begin
      if (n == inj_at) begin
        start = 1'b1;
        op = ~o;
        a = x ^ 32'h5a5a_1234;
        b = y + 32'd77;
      end
      if (n == inj_at + 1) start = 1'b0;
      if (n == rst_at) begin
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        void'(sbq.pop_back());
        model_hi = '0;
        model_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        return;
      end
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'(lat + 1));
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7fff_ffff;
      2:       return 32'hffff_ffff;
      3:       return 32'd0;
      4:       return 32'(-$urandom_range(1, 100));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div_zero", 64'(div_zero), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(1'b0, 32'd7, 32'hffff_fffd, -5, -5);
    do_op(1'b0, 32'h7fff_ffff, 32'h7fff_ffff, -5, -5);
    do_op(1'b1, 32'hffff_fff9, 32'd2, -5, -5);
    do_op(1'b1, 32'h8000_0000, 32'hffff_ffff, -5, -5);
    do_op(1'b1, 32'h0000_0451, 32'h20, -5, -5);  // leaves hi 0x11, lo 0x22
    do_op(1'b1, 32'd5, 32'd0, -5, -5);
    do_op(1'b0, 32'd123, 32'hffff_fe38, 9, -5);
    do_op(1'b0, 32'd1000, 32'd2000, -5, 14);
    do_op(1'b0, 32'd3, 32'd4, -5, -5);
    check("follow_on_lo", 64'(lo), 64'd12);

    for (int i = 0; i < 40; i++) begin
      logic o;
      logic [31:0] x, y;
      o = $urandom_range(0, 1);
      x = pick();
      y = pick();
      do_op(o, x, y, -5, -5);
    end

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
